// File: rtl/klein_pkg.sv
// Shared KLEIN definitions: block geometry, S-box table, rotations and the
// stage FSM encoding reused by the round controller.
package klein_pkg;

    localparam int unsigned KLEIN_BLOCK_W = 64;
    localparam int unsigned KLEIN_NIB_W   = 4;
    localparam int unsigned KLEIN_ROT     = 16;
    localparam int unsigned KLEIN_NIBS    = KLEIN_BLOCK_W / KLEIN_NIB_W;

    // Involutive S-box, so the same table serves encrypt and decrypt.
    localparam logic [KLEIN_NIB_W-1:0] KLEIN_SBOX [16] = '{
        4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
        4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5
    };

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSub  = 2'd1,
        StHold = 2'd2
    } klein_state_e;

    function automatic logic [KLEIN_BLOCK_W-1:0] klein_rotl(input logic [KLEIN_BLOCK_W-1:0] x);
        return {x[KLEIN_BLOCK_W-KLEIN_ROT-1:0], x[KLEIN_BLOCK_W-1 -: KLEIN_ROT]};
    endfunction

    function automatic logic [KLEIN_BLOCK_W-1:0] klein_rotr(input logic [KLEIN_BLOCK_W-1:0] x);
        return {x[KLEIN_ROT-1:0], x[KLEIN_BLOCK_W-1:KLEIN_ROT]};
    endfunction

endpackage

// File: rtl/klein_subrot_if.sv
// Block handshake bundle for klein_subrot; the stage itself uses the slave view.
interface klein_subrot_if;
    import klein_pkg::*;

    logic                     ivalid;
    logic                     oready;
    logic [KLEIN_BLOCK_W-1:0] idata;
    logic [KLEIN_BLOCK_W-1:0] ikey;
    logic                     iinv;
    logic                     ovalid;
    logic                     iready;
    logic [KLEIN_BLOCK_W-1:0] odata;
    logic                     obusy;

    modport slave (
        input  ivalid, idata, ikey, iinv, iready,
        output oready, ovalid, odata, obusy
    );

    modport master (
        output ivalid, idata, ikey, iinv, iready,
        input  oready, ovalid, odata, obusy
    );

endinterface

// File: rtl/klein_sbox4.sv
// Combinational 4-bit KLEIN S-box.
module klein_sbox4
    import klein_pkg::*;
(
    input  logic [KLEIN_NIB_W-1:0] i_nib,
    output logic [KLEIN_NIB_W-1:0] o_nib
);

    assign o_nib = KLEIN_SBOX[i_nib];

endmodule

// File: rtl/klein_subrot.sv
// Nibble-serial AddRoundKey/SubNibbles/RotateNibbles stage; NSBOX nibbles are
// substituted per cycle, MSB group first.
module klein_subrot
    import klein_pkg::*;
#(
    parameter int unsigned NSBOX = 4
) (
    input  logic           iclk,
    input  logic           irst_n,
    klein_subrot_if.slave  bus
);

    localparam int unsigned GROUPS   = KLEIN_NIBS / NSBOX;
    localparam logic [4:0]  LAST_CNT = 5'(GROUPS - 1);

    if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4 && NSBOX != 8 && NSBOX != 16) begin : g_bad_nsbox
        $fatal(1, "klein_subrot: NSBOX must be 1, 2, 4, 8 or 16");
    end

    klein_state_e             r_fsm, w_fsm_nxt;
    logic [KLEIN_BLOCK_W-1:0] r_state, w_state_nxt;
    logic [KLEIN_BLOCK_W-1:0] r_key, w_key_nxt;
    logic                     r_inv, w_inv_nxt;
    logic [4:0]               r_cnt, w_cnt_nxt;
    logic [KLEIN_BLOCK_W-1:0] r_odata, w_odata_nxt;

    logic [5:0]               w_off    [NSBOX];
    logic [KLEIN_NIB_W-1:0]   w_sb_in  [NSBOX];
    logic [KLEIN_NIB_W-1:0]   w_sb_out [NSBOX];
    logic [KLEIN_BLOCK_W-1:0] w_sub_state;

    // Bit offset of the nibble handled by each S-box lane in the current group.
    always_comb begin
        for (int j = 0; j < int'(NSBOX); j++) begin
            w_off[j]   = 6'((KLEIN_NIBS - 1 - 32'(r_cnt) * NSBOX - 32'(j)) * KLEIN_NIB_W);
            w_sb_in[j] = r_state[w_off[j] +: KLEIN_NIB_W];
        end
    end

    for (genvar g = 0; g < int'(NSBOX); g++) begin : g_sbox
        klein_sbox4 u_sbox (
            .i_nib (w_sb_in[g]),
            .o_nib (w_sb_out[g])
        );
    end

    always_comb begin
        w_sub_state = r_state;
        for (int j = 0; j < int'(NSBOX); j++) begin
            w_sub_state[w_off[j] +: KLEIN_NIB_W] = w_sb_out[j];
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_inv_nxt   = r_inv;
        w_cnt_nxt   = r_cnt;
        w_odata_nxt = r_odata;
        unique case (r_fsm)
            StIdle: begin
                if (bus.ivalid) begin
                    if (bus.iinv) begin
                        w_state_nxt = klein_rotr(bus.idata);
                        w_key_nxt   = bus.ikey;
                    end else begin
                        w_state_nxt = bus.idata ^ bus.ikey;
                    end
                    w_inv_nxt = bus.iinv;
                    w_cnt_nxt = '0;
                    w_fsm_nxt = StSub;
                end
            end
            StSub: begin
                w_state_nxt = w_sub_state;
                w_cnt_nxt   = r_cnt + 5'd1;
                if (r_cnt == LAST_CNT) begin
                    w_odata_nxt = r_inv ? (w_sub_state ^ r_key) : klein_rotl(w_sub_state);
                    w_fsm_nxt   = StHold;
                end
            end
            StHold: begin
                if (bus.iready) begin
                    w_fsm_nxt = StIdle;
                end
            end
            default: w_fsm_nxt = StIdle;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_fsm   <= StIdle;
            r_state <= '0;
            r_key   <= '0;
            r_inv   <= 1'b0;
            r_cnt   <= '0;
            r_odata <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_inv   <= w_inv_nxt;
            r_cnt   <= w_cnt_nxt;
            r_odata <= w_odata_nxt;
        end
    end

    assign bus.oready = (r_fsm == StIdle);
    assign bus.ovalid = (r_fsm == StHold);
    assign bus.obusy  = (r_fsm == StSub) || (r_fsm == StHold);
    assign bus.odata  = r_odata;

endmodule

// File: tb/tb_klein_subrot.sv
// Bench for klein_subrot at NSBOX = 1, 4 and 16: spec vectors, random blocks
// against a nibble-level model, backpressure hold and reset during SUB.
module tb_klein_subrot;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic        t_ivalid, t_iinv, t_iready;
    logic [63:0] t_idata, t_ikey;
    int          sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 iclk = ~iclk;

    klein_subrot_if bus_1 ();
    klein_subrot_if bus_4 ();
    klein_subrot_if bus_16 ();

    assign bus_1.ivalid  = t_ivalid && (sel == 0);
    assign bus_4.ivalid  = t_ivalid && (sel == 1);
    assign bus_16.ivalid = t_ivalid && (sel == 2);
    assign bus_1.idata   = t_idata;
    assign bus_4.idata   = t_idata;
    assign bus_16.idata  = t_idata;
    assign bus_1.ikey    = t_ikey;
    assign bus_4.ikey    = t_ikey;
    assign bus_16.ikey   = t_ikey;
    assign bus_1.iinv    = t_iinv;
    assign bus_4.iinv    = t_iinv;
    assign bus_16.iinv   = t_iinv;
    assign bus_1.iready  = t_iready;
    assign bus_4.iready  = t_iready;
    assign bus_16.iready = t_iready;

    klein_subrot #(.NSBOX(1))  u_dut_1  (.iclk(iclk), .irst_n(irst_n), .bus(bus_1));
    klein_subrot #(.NSBOX(4))  u_dut_4  (.iclk(iclk), .irst_n(irst_n), .bus(bus_4));
    klein_subrot #(.NSBOX(16)) u_dut_16 (.iclk(iclk), .irst_n(irst_n), .bus(bus_16));

    logic        m_oready, m_ovalid, m_obusy;
    logic [63:0] m_odata;

    always_comb begin
        m_oready = bus_1.oready;
        m_ovalid = bus_1.ovalid;
        m_obusy  = bus_1.obusy;
        m_odata  = bus_1.odata;
        if (sel == 1) begin
            m_oready = bus_4.oready;
            m_ovalid = bus_4.ovalid;
            m_obusy  = bus_4.obusy;
            m_odata  = bus_4.odata;
        end else if (sel == 2) begin
            m_oready = bus_16.oready;
            m_ovalid = bus_16.ovalid;
            m_obusy  = bus_16.obusy;
            m_odata  = bus_16.odata;
        end
    end

    function automatic int groups();
        if (sel == 0) return 16;
        if (sel == 1) return 4;
        return 1;
    endfunction

    localparam bit [3:0] SB [16] = '{7, 4, 10, 9, 1, 15, 11, 0, 12, 3, 2, 6, 8, 14, 13, 5};

    function automatic logic [63:0] model(input logic [63:0] d, input logic [63:0] k,
                                          input logic inv);
        logic [63:0] s;
        s = inv ? ((d >> 16) | (d << 48)) : (d ^ k);
        for (int i = 0; i < 16; i++) s[i*4 +: 4] = SB[s[i*4 +: 4]];
        return inv ? (s ^ k) : ((s << 16) | (s >> 48));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (NSBOX sel %0d): got %h expected %h", name, sel, act, exp);
        end
    endtask

    task automatic send_block(input logic [63:0] d, input logic [63:0] k, input logic inv,
                              input int hold, output logic [63:0] got);
        int c;
        logic [63:0] first;
        c = 0;
        while (!m_oready && c < 50) begin
            @(posedge iclk); #1;
            c++;
        end
        chk("oready_idle", 64'(m_oready), 64'd1);
        t_idata  = d;
        t_ikey   = k;
        t_iinv   = inv;
        t_ivalid = 1'b1;
        @(posedge iclk); #1;
        t_ivalid = 1'b0;
        t_idata  = {$urandom, $urandom};
        t_ikey   = {$urandom, $urandom};
        t_iinv   = ~inv;
        chk("busy_after_accept", 64'({m_obusy, m_oready}), 64'b10);
        c = 0;
        while (!m_ovalid && c < 40) begin
            t_ivalid = 1'($urandom);
            @(posedge iclk); #1;
            c++;
        end
        t_ivalid = 1'b0;
        chk("latency", 64'(c), 64'(groups()));
        got   = m_odata;
        first = m_odata;
        for (int h = 0; h < hold; h++) begin
            t_ivalid = 1'(h & 1);
            @(posedge iclk); #1;
            chk("hold_ovalid", 64'({m_ovalid, m_oready}), 64'b10);
            chk("hold_odata", m_odata, first);
        end
        t_ivalid = 1'b0;
        t_iready = 1'b1;
        @(posedge iclk); #1;
        t_iready = 1'b0;
        chk("release", 64'({m_ovalid, m_oready, m_obusy}), 64'b010);
    endtask

    typedef struct {
        string       name;
        logic [63:0] d;
        logic [63:0] k;
        logic        inv;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [63:0] got, got2, d, k;
        bit          seen;

        vecs[0] = '{"fwd_zero", 64'h0, 64'h0, 1'b0, 64'h7777777777777777};
        vecs[1] = '{"fwd_count", 64'h0123456789ABCDEF, 64'h0, 1'b0, 64'h1FB0C3268ED574A9};
        vecs[2] = '{"inv_count", 64'h1FB0C3268ED574A9, 64'h0, 1'b1, 64'h0123456789ABCDEF};
        vecs[3] = '{"inv_key", 64'h7777777777777777, 64'h0123456789ABCDEF, 1'b1,
                    64'h0123456789ABCDEF};

        t_ivalid = 1'b0;
        t_iinv   = 1'b0;
        t_iready = 1'b0;
        t_idata  = '0;
        t_ikey   = '0;
        sel      = 0;
        irst_n   = 1'b0;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_outputs", 64'({m_oready, m_ovalid, m_obusy}), 64'b100);
            chk("reset_odata", m_odata, 64'h0);
        end
        @(negedge iclk);
        irst_n = 1'b1;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int v = 0; v < 4; v++) begin
                send_block(vecs[v].d, vecs[v].k, vecs[v].inv, 0, got);
                chk(vecs[v].name, got, vecs[v].exp);
            end

            for (int r = 0; r < 6; r++) begin
                d = {$urandom, $urandom};
                k = {$urandom, $urandom};
                send_block(d, k, 1'b0, 0, got);
                chk("rand_fwd", got, model(d, k, 1'b0));
                send_block(got, k, 1'b1, 0, got2);
                chk("rand_roundtrip", got2, d);
                send_block(d, k, 1'b1, r % 3, got);
                chk("rand_inv", got, model(d, k, 1'b1));
            end

            send_block(64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 5, got);
            chk("fwd_allkey_hold", got, 64'h5555555555555555);

            // Abort a block in SUB; it must never show up at the output.
            while (!m_oready) begin
                @(posedge iclk); #1;
            end
            t_idata  = 64'h0123456789ABCDEF;
            t_ikey   = 64'h0;
            t_iinv   = 1'b0;
            t_ivalid = 1'b1;
            @(posedge iclk); #1;
            t_ivalid = 1'b0;
            chk("sub_before_reset", 64'(m_obusy), 64'd1);
            #2 irst_n = 1'b0;
            #1;
            chk("midsub_reset_flags", 64'({m_oready, m_ovalid, m_obusy}), 64'b100);
            chk("midsub_reset_odata", m_odata, 64'h0);
            @(negedge iclk);
            irst_n = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(posedge iclk); #1;
                if (m_ovalid) seen = 1'b1;
            end
            chk("no_partial_block", 64'(seen), 64'd0);
            send_block(64'h0123456789ABCDEF, 64'h0, 1'b0, 0, got);
            chk("after_reset_block", got, 64'h1FB0C3268ED574A9);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
